// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC share arbiter.
// FSM encoding, widths and a saturating counter helper.
package adc_pkg;

  localparam int ADC_DATA_W  = 12;
  localparam int TIMEOUT_DEF = 64;
  localparam int NUM_REQ_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/adc_share_arbiter_if.sv
// Client + ADC reader bundle for the share arbiter.
// slave = arbiter side, master = clients/ADC side.
interface adc_share_arbiter_if
  import adc_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = ADC_DATA_W
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] err;
  logic [DATA_W-1:0]  rd_data;
  logic               busy;
  logic               adc_start;
  logic               adc_ready;
  logic [DATA_W-1:0]  adc_data;
  logic [7:0]         timeout_cnt;

  modport slave (
    input  req, adc_ready, adc_data,
    output ack, err, rd_data, busy,
    output adc_start, timeout_cnt
  );

  modport master (
    output req, adc_ready, adc_data,
    input  ack, err, rd_data, busy,
    input  adc_start, timeout_cnt
  );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or
// after ptr_i, wrapping past N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          hit_o,
  output logic [PW-1:0] idx_o
);

  logic [PW:0] s;

  // scan far-to-near so the closest hit wins
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    s     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      s = {1'b0, ptr_i} + (PW + 1)'(off);
      if (s >= (PW + 1)'(N)) begin
        s = s - (PW + 1)'(N);
      end
      if (req_i[s[PW-1:0]]) begin
        hit_o = 1'b1;
        idx_o = s[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/adc_share_arbiter.sv
// Shares one ADC reader among NUM_REQ clients,
// round-robin, with a watchdog on adc_ready.
module adc_share_arbiter
  import adc_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = ADC_DATA_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  adc_share_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_e state_q, state_d;

  logic [PW-1:0] grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] pick_idx;
  logic          pick_hit;

  logic [WW-1:0] wd_q, wd_d;
  logic          expire;
  logic          ok_q, ok_d;

  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [NUM_REQ-1:0] sel_oh;
  logic [DATA_W-1:0]  rd_q, rd_d;
  logic               busy_q, busy_d;
  logic [7:0]         tcnt_q, tcnt_d;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  assign sel_oh = NUM_REQ'(1) << grant_q;
  assign expire = (wd_q == WW'(TIMEOUT - 1));

  // next state, watchdog and result capture
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    ok_d    = ok_q;
    ack_d   = '0;
    err_d   = '0;
    rd_d    = rd_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_hit) begin
          grant_d = pick_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.adc_ready) begin
          rd_d    = bus.adc_data;
          ok_d    = 1'b1;
          state_d = S_DONE;
        end else if (expire) begin
          ok_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_DONE: begin
        if (ok_q) begin
          ack_d = sel_oh;
        end else begin
          err_d  = sel_oh;
          tcnt_d = sat_inc8(tcnt_q);
        end
        ptr_d = (grant_q == PW'(NUM_REQ - 1))
              ? '0 : grant_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // busy spans grant through the ack/err cycle
    busy_d = (state_d != S_IDLE)
          || (state_q == S_DONE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      ok_q    <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      ok_q    <= ok_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.adc_start   = (state_q == S_START);
  assign bus.ack         = ack_q;
  assign bus.err         = err_q;
  assign bus.rd_data     = rd_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_adc_share_arbiter.sv
// Bench for adc_share_arbiter: timestamp model
// of each conversion plus directed and random runs.
module tb_adc_share_arbiter;
  import adc_pkg::*;

  localparam int N  = 4;
  localparam int DW = 12;
  localparam int TO = 64;

  typedef struct {
    logic [N-1:0]  v;
    int            c;
    logic [DW-1:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_share_arbiter_if #(
    .NUM_REQ (N),
    .DATA_W  (DW)
  ) bus ();

  adc_share_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus controls (written by main)
  logic [N-1:0]  req_drv = '0;
  bit            rand_req = 0;
  bit            rand_adc = 0;
  bit            auto_drop = 0;
  int            fix_delay = 3;
  logic [DW-1:0] fix_data = '0;
  int            spur_pct = 0;
  int            spur_req = 0;

  // model and driver state (written by monitor)
  bit            act_m = 0;
  bit            wait_m = 0;
  bit            ok_m = 0;
  int            g_m = 0;
  int            ts_m = 0;
  int            te_m = 0;
  int            ptr_m = 0;
  int            tcnt_m = 0;
  logic [DW-1:0] rdd_m = '0;
  int            rd_at = -1;
  logic [DW-1:0] rd_new = '0;
  int            tc_at = -1;
  int            cur_delay = 0;
  logic [DW-1:0] cur_data = '0;
  logic [N-1:0]  rnd_req = '0;
  int            spur_done = 0;

  ev_t ack_log[$];
  ev_t err_log[$];
  int  start_log[$];
  int  rdy_log[$];

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h want %0h",
               nm, cyc, a, e);
    end
  endtask

  function automatic int first_at(
    input logic [N-1:0] r, input int p);
    for (int o = 0; o < N; o++)
      if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  // per-cycle compare, input drive, model step
  always @(negedge clk) begin : mon
    logic [N-1:0]  e_ack, e_err, rq;
    logic          e_st, e_bz, rdy;
    logic [DW-1:0] dat;
    int            r;
    if (!reset) begin
      act_m = 0; wait_m = 0; ok_m = 0;
      ptr_m = 0; tcnt_m = 0; rdd_m = '0;
      rd_at = -1; tc_at = -1;
      ts_m = 0; te_m = 0;
    end
    if (rd_at == cyc) rdd_m = rd_new;
    if (tc_at == cyc && tcnt_m < 255) tcnt_m++;
    e_st = act_m && cyc == ts_m;
    e_bz = act_m && cyc >= ts_m
        && (wait_m || cyc <= te_m);
    e_ack = '0;
    e_err = '0;
    if (act_m && !wait_m && cyc == te_m) begin
      if (ok_m) e_ack = N'(1) << g_m;
      else      e_err = N'(1) << g_m;
    end
    chk("adc_start", bus.adc_start, e_st);
    chk("busy", bus.busy, e_bz);
    chk("ack", bus.ack, e_ack);
    chk("err", bus.err, e_err);
    chk("rd_data", bus.rd_data, rdd_m);
    chk("timeout_cnt", bus.timeout_cnt, tcnt_m);
    if (bus.adc_start === 1'b1)
      start_log.push_back(cyc);
    if (|bus.ack)
      ack_log.push_back('{bus.ack, cyc, bus.rd_data});
    if (|bus.err)
      err_log.push_back('{bus.err, cyc, bus.rd_data});

    if (rand_req) begin
      if ($urandom_range(0, 3) == 0)
        rnd_req = N'($urandom_range(0, 15));
      rq = rnd_req;
    end else begin
      rq = req_drv;
    end
    if (auto_drop) rq = rq & ~(bus.ack | bus.err);

    rdy = 1'b0;
    dat = DW'($urandom);
    if (reset && act_m && cur_delay != 0
        && cyc == ts_m + cur_delay) begin
      rdy = 1'b1;
      dat = cur_data;
      rdy_log.push_back(cyc);
    end else if (reset && spur_req != spur_done) begin
      rdy = 1'b1;
      dat = 12'h123;
      spur_done++;
    end else if (reset && spur_pct > 0
        && $urandom_range(0, 99) < spur_pct) begin
      rdy = 1'b1;
    end
    bus.req       = rq;
    bus.adc_ready = rdy;
    bus.adc_data  = dat;

    if (reset) begin
      if (act_m && wait_m) begin
        if (rdy && cyc > ts_m) begin
          ok_m = 1; wait_m = 0;
          te_m = cyc + 2;
          rd_at = cyc + 1; rd_new = dat;
          ptr_m = (g_m + 1) % N;
        end else if (cyc == ts_m + TO) begin
          ok_m = 0; wait_m = 0;
          te_m = cyc + 2;
          tc_at = cyc + 2;
          ptr_m = (g_m + 1) % N;
        end
      end else if ((!act_m || cyc >= te_m)
                   && rq != '0) begin
        g_m = first_at(rq, ptr_m);
        act_m = 1; wait_m = 1;
        ts_m = cyc + 1;
        if (rand_adc) begin
          r = $urandom_range(0, 9);
          cur_data = DW'($urandom);
          if (r == 0)      cur_delay = 0;
          else if (r == 1) cur_delay = TO;
          else if (r == 2) cur_delay = TO + 1;
          else cur_delay = $urandom_range(1, 12);
        end else begin
          cur_delay = fix_delay;
          cur_data  = fix_data;
        end
      end
    end
    cyc++;
  end

  function automatic int qsize(input int w);
    if (w == 0) return ack_log.size();
    if (w == 1) return err_log.size();
    return start_log.size();
  endfunction

  task automatic wait_n(input int w, input int n,
                        input int bud, input string nm);
    bit hit = 0;
    for (int k = 0; k < bud; k++) begin
      @(posedge clk);
      if (qsize(w) >= n) begin
        hit = 1;
        break;
      end
    end
    #1;
    chk(nm, hit, 1);
  endtask

  task automatic drain();
    bit idle = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (!act_m || (!wait_m && cyc > te_m + 1)) begin
        idle = 1;
        break;
      end
    end
    #1;
    chk("drain", idle, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic rr_seq(input logic [N-1:0] rv,
                        input int cnt,
                        input int exp_q[$],
                        input string nm);
    int a0;
    do_reset();
    a0 = ack_log.size();
    auto_drop = 0;
    fix_delay = 3;
    req_drv = rv;
    wait_n(0, a0 + cnt, 200, {nm, "_wait"});
    req_drv = '0;
    for (int k = 0; k < cnt; k++)
      chk(nm, ack_log[a0 + k].v, N'(1) << exp_q[k]);
    drain();
  endtask

  initial begin : main
    int a0, e0, s0, r0;
    bus.req = '0;
    bus.adc_ready = 1'b0;
    bus.adc_data = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_ack", bus.ack, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.adc_start, 0);
    chk("rst_rd", bus.rd_data, 0);
    chk("rst_tcnt", bus.timeout_cnt, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // single client 2, reply 14 cycles after start
    a0 = ack_log.size();
    s0 = start_log.size();
    r0 = rdy_log.size();
    auto_drop = 1;
    fix_delay = 14;
    fix_data = 12'hA5C;
    req_drv = 4'b0100;
    wait_n(0, a0 + 1, 100, "t1_wait");
    req_drv = '0;
    drain();
    chk("t1_ack", ack_log[a0].v, 4'b0100);
    chk("t1_data", ack_log[a0].d, 12'hA5C);
    chk("t1_lat_start",
        ack_log[a0].c - start_log[s0], 16);
    chk("t1_lat_ready",
        ack_log[a0].c - rdy_log[r0], 2);
    chk("t1_nstart", start_log.size() - s0, 1);

    rr_seq(4'b1111, 5, '{0, 1, 2, 3, 0}, "rr_all");
    rr_seq(4'b1001, 3, '{0, 3, 0}, "rr_wrap");

    // no reply: timeout on client 1
    do_reset();
    a0 = ack_log.size();
    e0 = err_log.size();
    s0 = start_log.size();
    auto_drop = 1;
    fix_delay = 0;
    req_drv = 4'b0010;
    wait_n(1, e0 + 1, 150, "t4_wait");
    chk("t4_err", err_log[e0].v, 4'b0010);
    chk("t4_lat", err_log[e0].c - start_log[s0], 66);
    chk("t4_tcnt", bus.timeout_cnt, 1);
    chk("t4_busy", bus.busy, 0);
    chk("t4_noack", ack_log.size() - a0, 0);
    req_drv = '0;
    @(posedge clk);
    #1;
    fix_delay = 5;
    fix_data = 12'h3C1;
    req_drv = 4'b0001;
    wait_n(0, a0 + 1, 100, "t4b_wait");
    req_drv = '0;
    chk("t4b_ack", ack_log[a0].v, 4'b0001);
    chk("t4b_data", ack_log[a0].d, 12'h3C1);
    drain();

    // stale ready while idle
    a0 = ack_log.size();
    e0 = err_log.size();
    spur_req++;
    repeat (6) @(posedge clk);
    #1;
    chk("spur_noack", ack_log.size() - a0, 0);
    chk("spur_noerr", err_log.size() - e0, 0);
    chk("spur_rd", bus.rd_data, 12'h3C1);

    // ready on the last watchdog cycle
    s0 = start_log.size();
    fix_delay = TO;
    fix_data = 12'h7E7;
    req_drv = 4'b0100;
    wait_n(0, a0 + 1, 150, "edge_wait");
    req_drv = '0;
    chk("edge_ack", ack_log[a0].v, 4'b0100);
    chk("edge_data", ack_log[a0].d, 12'h7E7);
    chk("edge_lat", ack_log[a0].c - start_log[s0],
        TO + 2);
    chk("edge_noerr", err_log.size() - e0, 0);
    drain();

    // reset in the middle of a conversion
    s0 = start_log.size();
    fix_delay = 0;
    req_drv = 4'b0001;
    wait_n(2, s0 + 1, 20, "t6_start");
    req_drv = '0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_ack", bus.ack, 0);
    chk("t6_err", bus.err, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_start0", bus.adc_start, 0);
    chk("t6_rd", bus.rd_data, 0);
    chk("t6_tcnt", bus.timeout_cnt, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    a0 = ack_log.size();
    fix_delay = 4;
    fix_data = 12'h0F0;
    req_drv = 4'b0011;
    wait_n(0, a0 + 2, 100, "t6_wait");
    req_drv = '0;
    chk("t6_first", ack_log[a0].v, 4'b0001);
    chk("t6_second", ack_log[a0 + 1].v, 4'b0010);
    drain();

    // randomized traffic against the model
    do_reset();
    auto_drop = 0;
    rand_adc = 1;
    spur_pct = 3;
    rand_req = 1;
    repeat (4000) @(posedge clk);
    #1;
    rand_req = 0;
    req_drv = '0;
    spur_pct = 0;
    rand_adc = 0;
    fix_delay = 3;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
